// File: rtl/ppx_pkg.sv
// ppx_pkg: shared definitions for the pulse-per-X tick tracker.
//   PPX_DEFAULT_CLK_FREQ : default expected period (cycles) when xcount == 0
//   REC_W / *_LSB / *_BIT : layout of a 66-bit tick record
//   ppx_state_e           : tracker state (IDLE, ACQ, TRACK)
//   ppx_pack()            : assembles a record from its fields
package ppx_pkg;

    localparam logic [31:0] PPX_DEFAULT_CLK_FREQ = 32'd10_000_000;

    localparam int unsigned REC_W     = 66;
    localparam int unsigned IDX_LSB   = 0;
    localparam int unsigned PER_LSB   = 32;
    localparam int unsigned EARLY_BIT = 64;
    localparam int unsigned LATE_BIT  = 65;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TRACK
    } ppx_state_e;

    function automatic logic [REC_W-1:0] ppx_pack(
        input logic [31:0] period,
        input logic [31:0] idx,
        input logic        early,
        input logic        late
    );
        logic [REC_W-1:0] r;
        r                 = '0;
        r[IDX_LSB +: 32]  = idx;
        r[PER_LSB +: 32]  = period;
        r[EARLY_BIT]      = early;
        r[LATE_BIT]       = late;
        return r;
    endfunction

endpackage

// File: rtl/ppx_record_fifo.sv
// ppx_record_fifo: synchronous FIFO for tick records.
//   clk, reset : clock, synchronous active-high reset (flushes pointers)
//   push/wdata : write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   rdata      : head entry, read straight from the storage flops, so it is
//                stable until popped; a push into an empty FIFO shows up on
//                the next cycle
//   full/empty : occupancy flags derived from the registered count
module ppx_record_fifo
    import ppx_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = REC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  wr_en, rd_en;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ppx_tick_tracker.sv
// ppx_tick_tracker: edge-detects the ppx strobe, measures the period between
// rising edges, checks it against the expected period and tracks lock.
// One record per edge is queued on a valid/ready stream.
//   clk, reset   : clock, synchronous active-high reset
//   ppx          : pulse from the generator (any width)
//   xcount       : expected period in cycles, 0 selects CLK_FREQ
//   clear_stats  : strobe clearing tick_count and overflow
//   m_tdata      : {period, tick_index}
//   m_tuser      : {late, early}
//   m_tvalid/m_tready : output stream handshake
//   locked       : tracker is in TRACK
//   overflow     : sticky, a record was dropped on a full FIFO
//   tick_count   : rising edges since reset / clear_stats
module ppx_tick_tracker
    import ppx_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ        = PPX_DEFAULT_CLK_FREQ,
    parameter logic [31:0] TOL             = 32'd16,
    parameter logic [3:0]  LOCK_COUNT      = 4'd3,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ppx,
    input  logic [31:0] xcount,
    input  logic        clear_stats,
    output logic [63:0] m_tdata,
    output logic [1:0]  m_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        locked,
    output logic        overflow,
    output logic [31:0] tick_count
);

    ppx_state_e   state_q, state_d;
    logic         ppx_d_q;
    logic [31:0]  period_cnt_q, period_cnt_d;
    logic [3:0]   good_cnt_q, good_cnt_d;
    logic [31:0]  tick_count_q, tick_count_d;
    logic         overflow_q, overflow_d;

    logic             rise;
    logic [31:0]      exp_per;
    logic [32:0]      exp_hi;
    logic             early, late, in_tol;
    logic [31:0]      idx;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty, pop;
    logic [3:0]       good_inc;

    assign m_tvalid   = !fifo_empty;
    assign pop        = m_tvalid && m_tready;
    assign m_tdata    = fifo_rdata[63:0];
    assign m_tuser    = {fifo_rdata[LATE_BIT], fifo_rdata[EARLY_BIT]};
    assign locked     = (state_q == TRACK);
    assign overflow   = overflow_q;
    assign tick_count = tick_count_q;

    always_comb begin
        rise     = ppx && !ppx_d_q;
        exp_per  = (xcount == '0) ? CLK_FREQ : xcount;
        exp_hi   = {1'b0, exp_per} + {1'b0, TOL};
        early    = (exp_per > TOL) && (period_cnt_q < (exp_per - TOL));
        late     = ({1'b0, period_cnt_q} > exp_hi);
        in_tol   = !early && !late;
        idx      = clear_stats ? '0 : tick_count_q;
        good_inc = good_cnt_q + 4'd1;

        // The first edge after reset has no reference, so it reports P=0.
        if (state_q == IDLE) begin
            rec = ppx_pack('0, idx, 1'b0, 1'b0);
        end else begin
            rec = ppx_pack(period_cnt_q, idx, early, late);
        end

        if (rise) begin
            period_cnt_d = 32'd1;
        end else if (period_cnt_q == '1) begin
            period_cnt_d = period_cnt_q;
        end else begin
            period_cnt_d = period_cnt_q + 32'd1;
        end

        tick_count_d = clear_stats ? '0 : tick_count_q;
        overflow_d   = clear_stats ? 1'b0 : overflow_q;
        if (rise) begin
            tick_count_d = idx + 32'd1;
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
        end

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (rise) begin
                    if (in_tol) begin
                        good_cnt_d = good_inc;
                        if (good_inc >= LOCK_COUNT) begin
                            state_d = TRACK;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            TRACK: begin
                // A missing edge is declared once the count reaches E+TOL.
                if ((rise && !in_tol) ||
                    (!rise && ({1'b0, period_cnt_q} == exp_hi))) begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ppx_d_q      <= 1'b1;
            period_cnt_q <= '0;
            good_cnt_q   <= '0;
            tick_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ppx_d_q      <= ppx;
            period_cnt_q <= period_cnt_d;
            good_cnt_q   <= good_cnt_d;
            tick_count_q <= tick_count_d;
            overflow_q   <= overflow_d;
        end
    end

    ppx_record_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rise),
        .wdata (rec),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ppx_tick_tracker.sv
module tb_ppx_tick_tracker;

    localparam int unsigned TB_CLK_FREQ = 1000;
    localparam int unsigned TB_TOL      = 2;
    localparam int unsigned TB_LOCK     = 3;
    localparam int unsigned TB_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ppx = 1'b1;
    logic [31:0] xcount = 32'd100;
    logic        clear_stats = 1'b0;
    logic [63:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        locked;
    logic        overflow;
    logic [31:0] tick_count;

    always #5 clk = ~clk;

    ppx_tick_tracker #(
        .CLK_FREQ        (32'd1000),
        .TOL             (32'd2),
        .LOCK_COUNT      (4'd3),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ppx         (ppx),
        .xcount      (xcount),
        .clear_stats (clear_stats),
        .m_tdata     (m_tdata),
        .m_tuser     (m_tuser),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .locked      (locked),
        .overflow    (overflow),
        .tick_count  (tick_count)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  u;
    } rec_t;

    rec_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: edge times, a lock streak and a FIFO occupancy count.
    bit          m_prev   = 1'b1;
    bit          m_seen   = 1'b0;
    bit          m_locked = 1'b0;
    int          m_streak = 0;
    bit [31:0]   m_ticks  = '0;
    bit          m_ovf    = 1'b0;
    int          mcount   = 0;
    longint      now      = 0;
    longint      m_last   = 0;

    // Model view of DUT outputs during the current cycle.
    bit          mon_en         = 1'b0;
    bit          exp_valid_now  = 1'b0;
    bit          exp_locked_now = 1'b0;
    bit          exp_ovf_now    = 1'b0;
    bit [31:0]   exp_ticks_now  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_tvalid",   64'(m_tvalid),   64'(exp_valid_now));
            chk("locked",     64'(locked),     64'(exp_locked_now));
            chk("overflow",   64'(overflow),   64'(exp_ovf_now));
            chk("tick_count", 64'(tick_count), 64'(exp_ticks_now));
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_record", m_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    rec_t r;
                    r = sb.pop_front();
                    chk("m_tdata", m_tdata, r.d);
                    chk("m_tuser", 64'(m_tuser), 64'(r.u));
                end
            end
        end
    end

    // One clock: drive inputs for the next edge and advance the model to it.
    task automatic step(input bit p, input logic [31:0] xc, input bit clr,
                        input bit rdy, input bit rst);
        longint e_per, el, per;
        bit     rise, pop, e, l;
        bit [31:0] idx;
        @(posedge clk);
        #2;
        exp_valid_now  = (mcount > 0);
        exp_locked_now = m_locked;
        exp_ovf_now    = m_ovf;
        exp_ticks_now  = m_ticks;
        ppx         = p;
        xcount      = xc;
        clear_stats = clr;
        m_tready    = rst ? 1'b0 : rdy;
        reset       = rst;
        mon_en      = 1'b1;
        now++;
        if (rst) begin
            m_prev = 1'b1; m_seen = 1'b0; m_locked = 1'b0; m_streak = 0;
            m_ticks = '0; m_ovf = 1'b0; mcount = 0;
            sb.delete();
        end else begin
            rise   = p && !m_prev;
            m_prev = p;
            e_per  = (xc == 0) ? longint'(TB_CLK_FREQ) : longint'(xc);
            el     = now - m_last;
            pop    = (mcount > 0) && rdy;
            if (clr) begin
                m_ticks = '0;
                m_ovf   = 1'b0;
            end
            if (rise) begin
                idx     = m_ticks;
                m_ticks = m_ticks + 1;
                if (!m_seen) begin
                    per = 0; e = 0; l = 0;
                    m_seen = 1'b1; m_streak = 0;
                end else begin
                    per = el;
                    e = (e_per > TB_TOL) && (per < e_per - TB_TOL);
                    l = per > e_per + TB_TOL;
                    if (!e && !l) begin
                        if (!m_locked) begin
                            m_streak++;
                            if (m_streak >= TB_LOCK) m_locked = 1'b1;
                        end
                    end else begin
                        m_streak = 0;
                        m_locked = 1'b0;
                    end
                end
                m_last = now;
                if (mcount == TB_DEPTH && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    sb.push_back('{d: {per[31:0], idx}, u: {l, e}});
                    mcount++;
                end
            end else if (m_locked && el == e_per + TB_TOL) begin
                m_locked = 1'b0;
                m_streak = 0;
            end
            if (pop) mcount--;
        end
    endtask

    function automatic bit rdy_gen(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(3) != 0);
    endfunction

    // n periods; each starts with a rising edge held for width cycles.
    task automatic pulse_train(input int n, input int per, input int width, input int jit,
                               input logic [31:0] xc, input int rdy_mode, input int clr_pct);
        for (int k = 0; k < n; k++) begin
            int p;
            p = per;
            if (jit > 0) p = per + int'($urandom_range(2 * jit)) - jit;
            for (int c = 0; c < p; c++) begin
                step(c < width, xc, ($urandom_range(99) < clr_pct), rdy_gen(rdy_mode), 1'b0);
            end
        end
    endtask

    task automatic quiet(input int n, input logic [31:0] xc, input int rdy_mode);
        for (int c = 0; c < n; c++) step(1'b0, xc, 1'b0, rdy_gen(rdy_mode), 1'b0);
    endtask

    initial begin
        // ppx held high through reset release must not count as an edge.
        for (int c = 0; c < 3; c++) step(1'b1, 32'd100, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) step(1'b1, 32'd100, 1'b0, 1'b1, 1'b0);
        quiet(5, 32'd100, 1);

        // 1-cycle pulses, then 25% duty, at xcount=100.
        pulse_train(6, 100, 1, 0, 32'd100, 1, 0);
        pulse_train(6, 100, 25, 0, 32'd100, 1, 0);

        // Missed pulse: timeout, late edge, relock.
        quiet(100, 32'd100, 1);
        pulse_train(6, 100, 1, 0, 32'd100, 1, 0);

        // Stall the stream to force drops, then drain and clear.
        pulse_train(5, 100, 1, 0, 32'd100, 0, 0);
        quiet(10, 32'd100, 1);
        step(1'b0, 32'd100, 1'b1, 1'b1, 1'b0);
        quiet(5, 32'd100, 1);

        // Default period, then an early edge.
        pulse_train(6, 1000, 1, 0, 32'd0, 2, 0);
        pulse_train(1, 990, 1, 0, 32'd0, 2, 0);
        pulse_train(2, 1000, 3, 0, 32'd0, 2, 0);

        // Fill the FIFO, then reset mid-stream.
        pulse_train(5, 50, 1, 0, 32'd50, 0, 0);
        step(1'b0, 32'd50, 1'b0, 1'b0, 1'b1);
        quiet(5, 32'd50, 1);

        // Randomized periods, widths, backpressure, clears and omissions.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] xc;
            int per, w;
            xc  = ($urandom_range(1) == 0) ? 32'd60 : 32'd40;
            per = int'(xc) + int'($urandom_range(8)) - 4;
            w   = int'($urandom_range(1, per / 2));
            if ($urandom_range(7) == 0) begin
                quiet(per, xc, 2);
            end else begin
                pulse_train(1, per, w, 0, xc, 2, 2);
            end
        end

        quiet(20, 32'd60, 1);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ppx_tick_tracker.md
Name: ppx_tick_tracker

Overview:
- Consumes the pulse-per-X (ppx) strobe from the pulse generator and rising-edge detects it; the pulse may be one cycle wide or have any duty cycle.
- Measures the period between edges in clk cycles, checks it against the expected period, and tracks lock.
- Emits one record per edge on a valid/ready stream, buffered through a small FIFO.
- Feeds the doppler update scheduler with time-tagged tick events plus early/late/missed health status.

Parameters:
- CLK_FREQ, 32'd10_000_000: expected period used when xcount==0.
- TOL, 32'd16: allowed period deviation in clk cycles, ±.
- LOCK_COUNT, 4'd3: consecutive in-tolerance periods required to assert locked.
- FIFO_DEPTH_LOG2, 2: record FIFO depth is 2**FIFO_DEPTH_LOG2 (default 4).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- ppx  in  1  pulse from the generator, same clk domain.
- xcount  in  32  expected period in cycles; 0 selects CLK_FREQ.
- clear_stats  in  1  one-cycle strobe: clears tick_count, tick index and overflow.
- m_tdata  out  64  record {period[31:0], tick_index[31:0]}.
- m_tuser  out  2  {late, early} flags for the record.
- m_tvalid  out  1  record valid.
- m_tready  in  1  downstream accept.
- locked  out  1  tracker locked to expected period.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- tick_count  out  32  rising edges seen since reset or clear_stats; wraps at 2^32.

Behaviour:
- Reset: m_tvalid=0, locked=0, overflow=0, tick_count=0, FIFO flushed, state=IDLE, period_cnt=0, good_cnt=0.
  - ppx_d resets to 1, so a ppx held high across reset release does not produce an edge.
- Edge detect: rise = ppx & ~ppx_d; ppx_d is registered each cycle.
- Period counter:
  - On a rise cycle: period_cnt <= 1.
  - Otherwise: period_cnt <= period_cnt+1, saturating at 32'hFFFF_FFFF.
  - Measured period P = period_cnt value in the rise cycle, so rises N cycles apart give P=N.
- Expected period: E = (xcount==0) ? CLK_FREQ : xcount.
  - Sampled at each comparison; changing xcount mid-operation does not reset lock.
- Flags:
  - early = (E > TOL) && (P < E-TOL).
  - late = P > E+TOL, computed at 33-bit width so there is no wrap.
  - in_tol = !early && !late.
- Record written in the rise cycle; m_tvalid is high the next cycle if the FIFO was empty (latency 1).
- State machine:
  - IDLE: on rise, emit {P=0, idx}, user=00, go to ACQ. No comparison.
  - ACQ:
    - rise & in_tol: good_cnt++. When good_cnt reaches LOCK_COUNT, go to TRACK and set locked=1 in the same update.
    - rise & !in_tol: good_cnt=0.
    - Every rise emits a record.
  - TRACK:
    - rise & in_tol: emit, stay.
    - rise & !in_tol: emit with flags, locked=0, good_cnt=0, go to ACQ.
    - Timeout (no rise and period_cnt == E+TOL): locked=0, good_cnt=0, go to ACQ. The eventual late edge emits with late=1.
- tick_index = tick_count value before increment; tick_count increments on every rise, including dropped records.
- clear_stats:
  - Zeroes tick_count and overflow; does not flush the FIFO or touch lock.
  - Coincident with a rise: that record gets idx 0 and tick_count becomes 1.
- FIFO:
  - Push on rise.
  - Pop when m_tvalid & m_tready.
  - Full & rise & no pop: record dropped, overflow <= 1 (sticky).
  - Full & rise & pop in the same cycle: push accepted.
  - Empty & push: no same-cycle bypass; the record appears on the next cycle.
  - m_tdata/m_tuser hold stable while m_tvalid & !m_tready.
- Reset mid-operation: all of the above reset values apply; queued records are lost.

Decomposition:
- Shared package ppx_pkg holds:
  - PPX_DEFAULT_CLK_FREQ;
  - the record width (66) and field offsets (IDX_LSB=0, PER_LSB=32, EARLY_BIT=64, LATE_BIT=65);
  - the state enum (IDLE, ACQ, TRACK).
- One sub-module: ppx_record_fifo, a synchronous FIFO of width 66 and depth 2**FIFO_DEPTH_LOG2, with full/empty outputs and registered outputs.

Test Plan:
All cases use CLK_FREQ=1000, TOL=2, LOCK_COUNT=3.
1. xcount=100, 1-cycle ppx every 100 clks -> records (idx0,P0,00), (idx1,P100,00)…; m_tvalid high 1 clk after each rise; locked rises with the 4th edge.
2. xcount=100, ppx 25 high / 75 low -> identical records; exactly one record per period; tick_count=5 after 5 edges.
3. Locked, one pulse omitted -> locked falls 102 clks after the last edge (period_cnt=E+TOL); the next edge gives P=200, m_tuser=10; relock after 3 good periods.
4. m_tready=0 for 5 edges -> 4 records held, overflow=1, tick_count=5; then m_tready=1 drains idx0..3 in order; clear_stats -> overflow=0, tick_count=0.
5. xcount=0, ppx every 1000 clks -> in_tol, locks; a ppx at 990 clks gives m_tuser=01 (early) and locked drops.
6. ppx held high through reset deassert -> no record until the next 0→1 transition; a mid-stream reset empties the FIFO, m_tvalid=0 the following cycle.
